// File: rtl/bus_controller_if.sv
// Bus controller interface: CPU-side request/completion signals plus the memory req/ack port.
// The master modport is the controller's view; the slave modport is the view of whatever
// surrounds it (requester and memory model).
interface bus_controller_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              BUS_start_transaction;
   logic              BUS_mode;
   logic [ADDR_W-1:0] BUS_addr;
   logic [DATA_W-1:0] BUS_wdata;
   logic [DATA_W-1:0] BUS_rdata;
   logic              BUS_rdata_valid;
   logic              BUS_write_done;
   logic              BUS_err;
   logic              BUS_busy;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  BUS_start_transaction, BUS_mode, BUS_addr, BUS_wdata, mem_ack, mem_rdata,
      output BUS_rdata, BUS_rdata_valid, BUS_write_done, BUS_err, BUS_busy,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output BUS_start_transaction, BUS_mode, BUS_addr, BUS_wdata, mem_ack, mem_rdata,
      input  BUS_rdata, BUS_rdata_valid, BUS_write_done, BUS_err, BUS_busy,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/bus_controller.sv
// Single-word memory transaction engine: accepts one read/write at a time from the control
// unit, runs a req/ack handshake to memory and returns a one-cycle completion or error pulse.
// Misaligned (non-word) addresses are rejected without touching memory.
// Optional: define BUS_TIMEOUT_EN to abort a request that sees no mem_ack within
// TIMEOUT_CYCLES request cycles (reported as an error pulse).
module bus_controller #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic             clk,
   input logic             rst,
   bus_controller_if.master bus
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              wdone_q, wdone_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

`ifdef BUS_TIMEOUT_EN
   // At least 8 bits, wider only if the limit needs it.
   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            tmo_hit;

   // Limit is reached in the REQ cycle whose count (cycles already waited) is one short.
   assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`endif

   // State and registered outputs; synchronous reset aborts any transaction silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         wdone_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         wdone_q  <= wdone_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
`ifdef BUS_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   // Next-state and next-output logic; completion pulses default low so they last one cycle.
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      wdone_d  = 1'b0;
      err_d    = 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_d    = tmo_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus.BUS_start_transaction) begin
               addr_d  = bus.BUS_addr;
               wdata_d = bus.BUS_wdata;
               if (bus.BUS_addr[1:0] != 2'b00) begin
                  // Rejected before memory sees it; mem_we stays low in DONE.
                  state_d = StDone;
                  err_d   = 1'b1;
                  we_d    = 1'b0;
               end else begin
                  state_d = StReq;
                  req_d   = 1'b1;
                  we_d    = bus.BUS_mode;
`ifdef BUS_TIMEOUT_EN
                  tmo_d   = '0;
`endif
               end
            end
         end
         StReq: begin
            if (bus.mem_ack) begin
               state_d = StDone;
               req_d   = 1'b0;
               we_d    = 1'b0;
               if (we_q) begin
                  wdone_d = 1'b1;
               end else begin
                  rdata_d  = bus.mem_rdata;
                  rvalid_d = 1'b1;
               end
`ifdef BUS_TIMEOUT_EN
            end else if (tmo_hit) begin
               state_d = StDone;
               req_d   = 1'b0;
               we_d    = 1'b0;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
`endif
            end
         end
         StDone: begin
            state_d = StIdle;
            we_d    = 1'b0;
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   assign bus.BUS_rdata       = rdata_q;
   assign bus.BUS_rdata_valid = rvalid_q;
   assign bus.BUS_write_done  = wdone_q;
   assign bus.BUS_err         = err_q;
   assign bus.BUS_busy        = busy_q;
   assign bus.mem_req         = req_q;
   assign bus.mem_we          = we_q;
   assign bus.mem_addr        = addr_q;
   assign bus.mem_wdata       = wdata_q;

endmodule
